// File: rtl/fpu_host_if.sv
// fpu_host_if: byte-wide host bus front end (operand regs, command FIFO, result FIFO, status) for the FPU core.
// Latency: CMD write -> cmd_valid next cycle; result push -> cmd_end next cycle; host reads are combinational.
// Backpressure: cmd_ready=0 holds the command head; res_ready=0 while the result FIFO is full; a CMD write
// into a full command FIFO is dropped and flagged. Optional macro FPU_RES_AUTOPOP_EN: ending a read of the
// result MSB byte also pops the result head.

// sync_fifo: generic single-clock FIFO with extra-bit pointers.
// Latency: push visible at head/count the cycle after the edge; head is read combinationally.
// Backpressure: none inside; the caller only pushes when not full or when popping in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    // storage and pointers; the pointer MSB distinguishes full from empty
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    assign head  = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;
endmodule

module fpu_host_if #(
    parameter int WORD_BYTES = 4,
    parameter int CMD_DEPTH  = 4,
    parameter int RES_DEPTH  = 4,
    parameter int OPC_W      = 8,
    parameter int ADDR_W     = 4
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [7:0]              databus_in,
    output logic [7:0]              databus_out,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    cs,
    input  logic                    rd,
    input  logic                    wr,
    input  logic                    end_ack,
    output logic                    cmd_end,
    output logic                    busy,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [OPC_W-1:0]        cmd_opcode,
    output logic [8*WORD_BYTES-1:0] cmd_a,
    output logic [8*WORD_BYTES-1:0] cmd_b,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [8*WORD_BYTES-1:0] res_data
);
    localparam int N         = WORD_BYTES;
    localparam int W         = 8 * N;
    localparam int CMD_ADDR  = 2 * N;
    localparam int RES_LO    = 2 * N + 1;
    localparam int RES_HI    = 3 * N;
    localparam int STAT_ADDR = 3 * N + 1;
    localparam int CW        = OPC_W + 2 * W;
    localparam int CAW       = $clog2(CMD_DEPTH);
    localparam int RAW       = $clog2(RES_DEPTH);
    localparam int IMAX      = CMD_DEPTH + RES_DEPTH;
    localparam int IW        = $clog2(IMAX + 1);

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [31:0]   addr_w;
    logic          wr_q;
    logic          end_ack_q;
    logic          wr_evt;
    logic          wr_cmd;
    logic          wr_stat;
    logic          ack_rise;
    logic          auto_pop;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [CW-1:0] cmd_wdata;
    logic [CW-1:0] cmd_head;
    logic [CAW:0]  cmd_count;
    logic          cmd_full;
    logic          cmd_empty;
    logic          cmd_push;
    logic          cmd_pop;
    logic [W-1:0]  res_head;
    logic [RAW:0]  res_count;
    logic          res_full;
    logic          res_empty;
    logic          res_push;
    logic          res_pop;
    logic [IW-1:0] inflight;
    logic          cmd_ovf;
    logic          res_rd_empty_err;
    logic          rd_res_empty;
    logic [31:0]   res_count_w;
    logic [3:0]    res_cnt_sat;
    logic [7:0]    status;

    // reset asserts immediately and is released two clocks later, in step with clk
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign addr_w = 32'(addr);

    // strobe sampling for one-action-per-strobe edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b1;
            end_ack_q <= 1'b0;
        end else begin
            wr_q      <= wr;
            end_ack_q <= end_ack;
        end
    end

    assign wr_evt   = !cs && !wr && wr_q;
    assign wr_cmd   = wr_evt && (addr_w == 32'(CMD_ADDR));
    assign wr_stat  = wr_evt && (addr_w == 32'(STAT_ADDR));
    assign ack_rise = end_ack && !end_ack_q;

`ifdef FPU_RES_AUTOPOP_EN
    logic              rd_q;
    logic              cs_q;
    logic [ADDR_W-1:0] addr_q;

    // remember the read cycle so its rd deassertion can be tied to the result MSB address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= 1'b1;
            cs_q   <= 1'b1;
            addr_q <= '0;
        end else begin
            rd_q   <= rd;
            cs_q   <= cs;
            addr_q <= addr;
        end
    end
    assign auto_pop = rd && !rd_q && !cs_q && (32'(addr_q) == 32'(RES_HI));
`else
    assign auto_pop = 1'b0;
`endif

    // operand byte registers; they keep their value across CMD writes so operands can be reused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa <= '0;
            opb <= '0;
        end else if (wr_evt) begin
            for (int i = 0; i < N; i++) begin
                if (addr_w == 32'(i)) begin
                    opa[8*i +: 8] <= databus_in;
                end
                if (addr_w == 32'(N + i)) begin
                    opb[8*i +: 8] <= databus_in;
                end
            end
        end
    end

    assign cmd_full  = (32'(cmd_count) == 32'(CMD_DEPTH));
    assign cmd_empty = (cmd_count == '0);
    assign cmd_valid = !cmd_empty;
    assign cmd_pop   = cmd_valid && cmd_ready;
    assign cmd_push  = wr_cmd && (!cmd_full || cmd_pop);
    assign cmd_wdata = {databus_in[OPC_W-1:0], opa, opb};
    assign {cmd_opcode, cmd_a, cmd_b} = cmd_head;

    sync_fifo #(.W(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .arst_n(rst_n),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .wdata (cmd_wdata),
        .head  (cmd_head),
        .count (cmd_count)
    );

    assign res_full  = (32'(res_count) == 32'(RES_DEPTH));
    assign res_empty = (res_count == '0);
    assign res_pop   = (ack_rise || auto_pop) && !res_empty;
    assign res_ready = !res_full || res_pop;
    assign res_push  = res_valid && res_ready;
    assign cmd_end   = !res_empty;

    sync_fifo #(.W(W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk   (clk),
        .arst_n(rst_n),
        .push  (res_push),
        .pop   (res_pop),
        .wdata (res_data),
        .head  (res_head),
        .count (res_count)
    );

    // commands handed to the core whose result has not come back yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (cmd_pop && !res_push && (32'(inflight) != 32'(IMAX))) begin
            inflight <= inflight + 1'b1;
        end else if (res_push && !cmd_pop && (inflight != '0)) begin
            inflight <= inflight - 1'b1;
        end
    end

    assign busy = !cmd_empty || (inflight != '0);

    assign rd_res_empty = !cs && !rd && res_empty &&
                          (addr_w >= 32'(RES_LO)) && (addr_w <= 32'(RES_HI));

    // sticky error flags; host clears them by writing STATUS with the flag bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ovf          <= 1'b0;
            res_rd_empty_err <= 1'b0;
        end else begin
            if (wr_cmd && cmd_full && !cmd_pop) begin
                cmd_ovf <= 1'b1;
            end else if (wr_stat && databus_in[2]) begin
                cmd_ovf <= 1'b0;
            end
            if (rd_res_empty) begin
                res_rd_empty_err <= 1'b1;
            end else if (wr_stat && databus_in[3]) begin
                res_rd_empty_err <= 1'b0;
            end
        end
    end

    assign res_count_w = 32'(res_count);
    assign res_cnt_sat = (res_count_w > 32'd15) ? 4'hF : res_count_w[3:0];
    assign status      = {res_cnt_sat, res_rd_empty_err, cmd_ovf, res_empty, cmd_full};

    // host read mux; reads have no side effects beyond the empty-read error flag
    always_comb begin
        databus_out = 8'h00;
        if (!cs && !rd) begin
            for (int i = 0; i < N; i++) begin
                if (addr_w == 32'(i)) begin
                    databus_out = opa[8*i +: 8];
                end
                if (addr_w == 32'(N + i)) begin
                    databus_out = opb[8*i +: 8];
                end
                if ((addr_w == 32'(RES_LO + i)) && !res_empty) begin
                    databus_out = res_head[8*i +: 8];
                end
            end
            if (addr_w == 32'(STAT_ADDR)) begin
                databus_out = status;
            end
        end
    end
endmodule

// File: tb/tb_fpu_host_if.sv
// Testbench for fpu_host_if: default 4-byte instance checked every cycle against a queue-based model,
// plus an 8-byte loopback instance checked with literal values.
// Build with FPU_RES_AUTOPOP_EN defined to exercise the read-triggered pop.
module tb_fpu_host_if;
    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- default instance (WORD_BYTES=4) ----------------
    logic [7:0]  din0 = 8'h00;
    logic [7:0]  dout0;
    logic [3:0]  addr0 = 4'h0;
    logic        cs0 = 1'b1, rd0 = 1'b1, wr0 = 1'b1, ack0 = 1'b0;
    logic        cmd_end0, busy0, cmd_valid0, res_ready0;
    logic        cmd_ready0 = 1'b0, res_valid0 = 1'b0;
    logic [7:0]  opc0;
    logic [31:0] a0, b0;
    logic [31:0] res_data0 = 32'h0;

    fpu_host_if u0 (
        .clk(clk), .arst_n(arst_n), .databus_in(din0), .databus_out(dout0), .addr(addr0),
        .cs(cs0), .rd(rd0), .wr(wr0), .end_ack(ack0), .cmd_end(cmd_end0), .busy(busy0),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_opcode(opc0), .cmd_a(a0), .cmd_b(b0),
        .res_valid(res_valid0), .res_ready(res_ready0), .res_data(res_data0)
    );

    // ---------------- wide instance (WORD_BYTES=8) ----------------
    logic [7:0]  din1 = 8'h00;
    logic [7:0]  dout1;
    logic [4:0]  addr1 = 5'h0;
    logic        cs1 = 1'b1, rd1 = 1'b1, wr1 = 1'b1, ack1 = 1'b0;
    logic        cmd_end1, busy1, cmd_valid1, res_ready1;
    logic        cmd_ready1 = 1'b0, res_valid1 = 1'b0;
    logic [7:0]  opc1;
    logic [63:0] a1, b1;
    logic [63:0] res_data1 = 64'h0;

    fpu_host_if #(.WORD_BYTES(8), .ADDR_W(5)) u1 (
        .clk(clk), .arst_n(arst_n), .databus_in(din1), .databus_out(dout1), .addr(addr1),
        .cs(cs1), .rd(rd1), .wr(wr1), .end_ack(ack1), .cmd_end(cmd_end1), .busy(busy1),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_opcode(opc1), .cmd_a(a1), .cmd_b(b1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1)
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of u0 ----------------
    logic [31:0] m_a = 32'h0, m_b = 32'h0;
    logic [71:0] m_cq[$];
    logic [31:0] m_rq[$];
    int          m_inflight = 0;
    bit          m_ovf = 0, m_err = 0;
    bit          m_wr_p = 1, m_ack_p = 0, m_rd_p = 1, m_cs_p = 1;
    logic [3:0]  m_addr_p = 4'h0;

    function automatic bit m_pop_req();
        bit r;
        r = ack0 && !m_ack_p;
`ifdef FPU_RES_AUTOPOP_EN
        if (rd0 && !m_rd_p && !m_cs_p && (m_addr_p == 4'd12)) r = 1'b1;
`endif
        return r && (m_rq.size() > 0);
    endfunction

    function automatic logic [7:0] m_status();
        int n;
        n = m_rq.size();
        if (n > 15) n = 15;
        return {4'(n), m_err, m_ovf, m_rq.size() == 0, m_cq.size() == 4};
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        int ai;
        ai = int'(a);
        if (ai < 4) return 8'(m_a >> (8 * ai));
        if (ai < 8) return 8'(m_b >> (8 * (ai - 4)));
        if (ai >= 9 && ai <= 12) return (m_rq.size() == 0) ? 8'h00 : 8'(m_rq[0] >> (8 * (ai - 9)));
        if (ai == 13) return m_status();
        return 8'h00;
    endfunction

    // model state advances on the same edges the DUT samples
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_a = 0; m_b = 0; m_cq.delete(); m_rq.delete(); m_inflight = 0;
            m_ovf = 0; m_err = 0; m_wr_p = 1; m_ack_p = 0; m_rd_p = 1; m_cs_p = 1; m_addr_p = 0;
        end else begin
            bit cpop, rpop, rpush, wev;
            int ai;
            cpop  = (m_cq.size() > 0) && cmd_ready0;
            rpop  = m_pop_req();
            rpush = res_valid0 && ((m_rq.size() < 4) || rpop);
            wev   = !cs0 && !wr0 && m_wr_p;
            ai    = int'(addr0);
            if (wev && ai == 13 && din0[3]) m_err = 0;
            if (!cs0 && !rd0 && ai >= 9 && ai <= 12 && m_rq.size() == 0) m_err = 1;
            if (cpop) begin void'(m_cq.pop_front()); m_inflight++; end
            if (wev) begin
                if (ai < 4) m_a[8*ai +: 8] = din0;
                else if (ai < 8) m_b[8*(ai-4) +: 8] = din0;
                else if (ai == 8) begin
                    if (m_cq.size() < 4) m_cq.push_back({din0, m_a, m_b});
                    else m_ovf = 1;
                end else if (ai == 13 && din0[2]) m_ovf = 0;
            end
            if (rpop) void'(m_rq.pop_front());
            if (rpush) begin
                m_rq.push_back(res_data0);
                if (m_inflight > 0) m_inflight--;
            end
            m_wr_p = wr0; m_ack_p = ack0; m_rd_p = rd0; m_cs_p = cs0; m_addr_p = addr0;
        end
    end

    // every-cycle comparison of u0 against the model, on the inactive edge
    always @(negedge clk) begin
        chk("mdl_ctl {cmd_valid,cmd_end,busy,res_ready}",
            80'({cmd_valid0, cmd_end0, busy0, res_ready0}),
            80'({m_cq.size() > 0, m_rq.size() > 0, (m_cq.size() > 0) || (m_inflight != 0),
                 (m_rq.size() < 4) || m_pop_req()}));
        if (m_cq.size() > 0) chk("mdl_cmd_head", 80'({opc0, a0, b0}), 80'(m_cq[0]));
        chk("mdl_databus_out", 80'(dout0), 80'((!cs0 && !rd0) ? m_read(addr0) : 8'h00));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bw(input int a, input logic [7:0] d);
        addr0 = 4'(a); din0 = d; cs0 = 0; wr0 = 0;
        tick();
        wr0 = 1; cs0 = 1;
        tick();
    endtask

    task automatic bw_word(input int base, input logic [31:0] v);
        for (int i = 0; i < 4; i++) bw(base + i, v[8*i +: 8]);
    endtask

    task automatic br(input int a, input logic [7:0] exp, input string nm);
        addr0 = 4'(a); cs0 = 0; rd0 = 0;
        tick();
        chk(nm, 80'(dout0), 80'(exp));
        rd0 = 1;
        tick();
        cs0 = 1;
    endtask

    task automatic ack();
        ack0 = 1; tick(); ack0 = 0; tick();
    endtask

    task automatic bw1(input int a, input logic [7:0] d);
        addr1 = 5'(a); din1 = d; cs1 = 0; wr1 = 0;
        tick();
        wr1 = 1; cs1 = 1;
        tick();
    endtask

    task automatic br1(input int a, input logic [7:0] exp, input string nm);
        addr1 = 5'(a); cs1 = 0; rd1 = 0;
        tick();
        chk(nm, 80'(dout1), 80'(exp));
        rd1 = 1;
        tick();
        cs1 = 1;
    endtask

    initial begin
        logic [63:0] pi_d;
        logic [63:0] one_d;
        pi_d  = 64'h400921FB54442D18;
        one_d = 64'h3FF0000000000000;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_u0_outputs {cmd_end,busy,cmd_valid,res_ready,dout}",
            80'({cmd_end0, busy0, cmd_valid0, res_ready0, dout0}), 80'({4'b0001, 8'h00}));
        chk("rst_u1_outputs {cmd_end,busy,cmd_valid,res_ready,dout}",
            80'({cmd_end1, busy1, cmd_valid1, res_ready1, dout1}), 80'({4'b0001, 8'h00}));
        arst_n = 1;
        repeat (4) tick();

        // single multiply: 23.0 * 47.0 = 1081.0
        bw_word(0, 32'h41B80000);
        bw_word(4, 32'h423C0000);
        bw(8, 8'h03);
        chk("t1_cmd_valid", 80'(cmd_valid0), 80'(1));
        chk("t1_head", 80'({opc0, a0, b0}), 80'({8'h03, 32'h41B80000, 32'h423C0000}));
        cmd_ready0 = 1; tick(); cmd_ready0 = 0;
        chk("t1_busy_inflight", 80'({busy0, cmd_valid0}), 80'(2'b10));
        res_data0 = 32'h44872000; res_valid0 = 1; tick(); res_valid0 = 0;
        chk("t1_cmd_end_rise", 80'(cmd_end0), 80'(1));
        br(9,  8'h00, "t1_res_b0");
        br(10, 8'h20, "t1_res_b1");
        br(11, 8'h87, "t1_res_b2");
        br(12, 8'h44, "t1_res_b3");
        br(13, 8'h10, "t1_status");
        ack0 = 1; tick();
        chk("t1_ack_cmd_end_busy", 80'({cmd_end0, busy0}), 80'(2'b00));
        ack0 = 0; tick();

        // command overflow with the core stalled
        for (int i = 1; i <= 5; i++) bw(8, 8'(i));
        br(13, 8'h07, "t2_status_ovf_full");
        chk("t2_head_opc", 80'(opc0), 80'(8'h01));
        bw(13, 8'h04);
        br(13, 8'h03, "t2_status_ovf_clr");

        // drain commands, return four results with no ack
        cmd_ready0 = 1; repeat (4) tick(); cmd_ready0 = 0;
        chk("t3_busy_all_inflight", 80'({cmd_valid0, busy0}), 80'(2'b01));
        res_valid0 = 1;
        for (int i = 0; i < 4; i++) begin
            res_data0 = 32'h1000 + 32'(i);
            tick();
        end
        res_valid0 = 0;
        chk("t3_res_ready_full", 80'(res_ready0), 80'(0));
        br(13, 8'h40, "t3_status_cnt4");
        ack0 = 1; tick();
        chk("t3_res_ready_after_ack", 80'(res_ready0), 80'(1));
        ack0 = 0; tick();
        br(13, 8'h30, "t3_status_cnt3");
        br(9, 8'h01, "t3_head_after_ack");
        res_data0 = 32'h2000; res_valid0 = 1; tick(); res_valid0 = 0;
        chk("t3_refull", 80'(res_ready0), 80'(0));
        res_data0 = 32'h3000; res_valid0 = 1; ack0 = 1; #1;
        chk("t3_ready_on_full_pop", 80'(res_ready0), 80'(1));
        tick(); res_valid0 = 0; ack0 = 0; tick();
        br(13, 8'h40, "t3_status_push_pop_full");
        br(9, 8'h02, "t3_head_push_pop_full");
        repeat (4) ack();
        br(9, 8'h00, "t3_empty_read");
        br(13, 8'h0A, "t3_status_rd_empty_err");
        bw(13, 8'h08);
        br(13, 8'h02, "t3_status_err_clr");

        // full command FIFO with a same-cycle pop accepts the push
        for (int i = 0; i < 4; i++) bw(8, 8'h11 + 8'(i));
        addr0 = 4'd8; din0 = 8'h15; cs0 = 0; wr0 = 0; cmd_ready0 = 1;
        tick();
        cmd_ready0 = 0; wr0 = 1; cs0 = 1;
        tick();
        br(13, 8'h03, "t4_status_full_no_ovf");
        chk("t4_head_opc", 80'(opc0), 80'(8'h12));
        cmd_ready0 = 1; repeat (2) tick(); cmd_ready0 = 0;
        chk("t4_busy_two_queued", 80'({cmd_valid0, busy0}), 80'(2'b11));

        // reset mid-operation
        arst_n = 0; #1;
        chk("t5_rst_outputs {cmd_end,busy,cmd_valid,res_ready,dout}",
            80'({cmd_end0, busy0, cmd_valid0, res_ready0, dout0}), 80'({4'b0001, 8'h00}));
        tick(); tick();
        arst_n = 1;
        repeat (4) tick();
        bw_word(0, 32'h3F800000);
        bw_word(4, 32'h40000000);
        bw(8, 8'h01);
        chk("t5_head", 80'({opc0, a0, b0}), 80'({8'h01, 32'h3F800000, 32'h40000000}));
        cmd_ready0 = 1; tick(); cmd_ready0 = 0;
        res_data0 = 32'h40400000; res_valid0 = 1; tick(); res_valid0 = 0;
        br(12, 8'h40, "t5_res_b3");
        br(11, 8'h40, "t5_res_b2");
        br(13, 8'h10, "t5_status");
        ack();
        chk("t5_done", 80'({cmd_end0, busy0}), 80'(2'b00));

        // result reads with and without autopop
        res_valid0 = 1;
        res_data0 = 32'hAAAA0001; tick();
        res_data0 = 32'hBBBB0002; tick();
        res_valid0 = 0;
        br(9,  8'h01, "t6_r0_b0");
        br(10, 8'h00, "t6_r0_b1");
        br(11, 8'hAA, "t6_r0_b2");
        br(12, 8'hAA, "t6_r0_b3");
`ifdef FPU_RES_AUTOPOP_EN
        br(9,  8'h02, "t6_autopop_head");
        br(12, 8'hBB, "t6_autopop_r1_b3");
        chk("t6_autopop_empty", 80'(cmd_end0), 80'(0));
`else
        br(9, 8'h01, "t6_no_autopop_head");
        ack();
        br(9, 8'h02, "t6_ack_head");
        ack();
        chk("t6_empty", 80'(cmd_end0), 80'(0));
`endif

        // 8-byte loopback
        for (int i = 0; i < 8; i++) bw1(i, pi_d[8*i +: 8]);
        for (int i = 0; i < 8; i++) bw1(8 + i, one_d[8*i +: 8]);
        bw1(16, 8'h03);
        chk("t7_head", 80'({cmd_valid1, a1}), {15'h0, 1'b1, pi_d});
        chk("t7_head_b", 80'(b1), 80'(one_d));
        res_data1 = a1; cmd_ready1 = 1; tick(); cmd_ready1 = 0;
        res_valid1 = 1; tick(); res_valid1 = 0;
        for (int i = 0; i < 8; i++) br1(17 + i, pi_d[8*i +: 8], $sformatf("t7_res_b%0d", i));
        br1(25, 8'h10, "t7_status");
        ack1 = 1; tick(); ack1 = 0; tick();
        chk("t7_done", 80'({cmd_end1, busy1}), 80'(2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
